cb_seq: RTL

//  Sequencer for the checkerboard pattern generator (cb). On a start pulse it

---
 rtl/cb_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cb_seq.sv
// cb_seq: sequencer for the checkerboard pattern generator (cb).
// On an accepted start it clears cb, then for each address in
// [addr_start, addr_stop] steps cb once, captures its data word and issues
// one write request over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   start, abort        run control (abort has highest priority)
//   addr_start/stop     inclusive address range, latched on start
//   num_levels          levels per cell, latched on start, drives cb_levels
//   cb_clr, cb_enable   clear / step pulses to cb
//   cb_levels           latched level count to cb
//   cb_data             cb data word, valid one cycle after cb_enable
//   req_valid/ready     write request handshake
//   req_addr, req_data  write request payload (stable while valid)
//   busy, done, err     status; done/err are 1-cycle pulses
//   wr_count            writes accepted in the current/last run
module cb_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 48,
  parameter int LVL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_stop,
  input  logic [LVL_W-1:0]  num_levels,
  output logic              cb_clr,
  output logic              cb_enable,
  output logic [LVL_W-1:0]  cb_levels,
  input  logic [DATA_W-1:0] cb_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_STEP, S_CAPT, S_ISSUE, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] stop_q;
  logic              bad_q;
  logic              bad_cfg;
  logic              start_ok;
  logic              hs;
  logic              last;

  assign bad_cfg  = (addr_start > addr_stop) || (num_levels == '0);
  assign start_ok = (state == S_IDLE) && start && !abort;
  assign hs       = (state == S_ISSUE) && req_valid && req_ready;
  // Compared before increment, so a range ending at the top address
  // terminates without wrapping.
  assign last     = (addr == stop_q);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_n = bad_cfg ? S_DONE : S_CLR;
      S_CLR:   state_n = S_STEP;
      S_STEP:  state_n = S_CAPT;
      S_CAPT:  state_n = S_ISSUE;
      S_ISSUE: if (hs) state_n = last ? S_DONE : S_STEP;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      stop_q    <= '0;
      bad_q     <= 1'b0;
      cb_levels <= '0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      wr_count  <= '0;
    end else begin
      if (start_ok) begin
        addr      <= addr_start;
        stop_q    <= addr_stop;
        cb_levels <= num_levels;
        bad_q     <= bad_cfg;
        wr_count  <= '0;
      end
      if (state == S_CAPT) begin
        req_data  <= cb_data;
        req_addr  <= addr;
        req_valid <= 1'b1;
      end
      // A handshake coinciding with abort still counts as accepted.
      if (hs) begin
        wr_count  <= wr_count + 1'b1;
        req_valid <= 1'b0;
        if (!last) addr <= addr + 1'b1;
      end
      if (abort) req_valid <= 1'b0;
    end
  end

  assign cb_clr    = (state == S_CLR);
  assign cb_enable = (state == S_STEP);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = (state == S_DONE) && bad_q;

endmodule
